coin_acceptor: RTL



---
 rtl/coin_acceptor_if.sv | 16 +
 rtl/coin_acceptor.sv | 104 ++++++++++
 2 files changed

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin-slot sensor in, qualified pulses and status out; coin_total present only with COIN_ACCEPTOR_TOTAL_EN
interface coin_acceptor_if;
    logic       coin_raw;
    logic       coin;
    logic       reject;
    logic       jam;
    logic       busy;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [7:0] coin_total;
    modport master (output coin_raw, input coin, reject, jam, busy, coin_total);
    modport slave  (input coin_raw, output coin, reject, jam, busy, coin_total);
`else
    modport master (output coin_raw, input coin, reject, jam, busy);
    modport slave  (input coin_raw, output coin, reject, jam, busy);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronise and debounce a coin-slot sensor, qualify the high width, flag jams and lock out re-insertion; COIN_ACCEPTOR_TOTAL_EN adds coin_total
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int MIN_W      = 3,
    parameter int MAX_W      = 20,
    parameter int GAP_CYCLES = 5
) (
    input  logic           clk,
    input  logic           reset,
    coin_acceptor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKOUT, JAM} state_t;
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] MIN_V    = 8'(MIN_W);
    localparam logic [7:0] MAX_V    = 8'(MAX_W);

    state_t     state, state_nxt;
    logic       sync1, sync2, deb, deb_q, rise, fall;
    logic [7:0] deb_cnt, width, width_nxt, lock_cnt, lock_nxt;
    logic       coin_nxt, reject_nxt;

    assign rise     = deb & ~deb_q;
    assign fall     = ~deb & deb_q;
    assign bus.jam  = state == JAM;
    assign bus.busy = state != IDLE;

    // two-flop synchroniser feeding a level that flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.coin_raw;
            sync2 <= sync1;
            deb_q <= deb;
            if (sync2 == deb) deb_cnt <= '0;
            else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else deb_cnt <= deb_cnt + 8'd1;
        end

    // next state, width/lockout counting and pulse decisions; falling edge is checked before the jam limit
    always_comb begin
        state_nxt  = state;
        width_nxt  = width;
        lock_nxt   = lock_cnt;
        coin_nxt   = 1'b0;
        reject_nxt = 1'b0;
        case (state)
            IDLE:
                if (rise) begin
                    state_nxt = MEASURE;
                    width_nxt = 8'd1;
                end
            MEASURE:
                if (fall) begin
                    coin_nxt   = (width >= MIN_V) && (width <= MAX_V);
                    reject_nxt = !coin_nxt;
                    state_nxt  = LOCKOUT;
                    lock_nxt   = '0;
                end else if (width > MAX_V) begin
                    state_nxt  = JAM;
                    reject_nxt = 1'b1;
                end else width_nxt = (width == 8'hFF) ? width : width + 8'd1;
            LOCKOUT:
                if (lock_cnt == GAP_LAST) state_nxt = IDLE;
                else lock_nxt = lock_cnt + 8'd1;
            JAM:
                if (!deb) begin
                    state_nxt = LOCKOUT;
                    lock_nxt  = '0;
                end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, counters and registered coin/reject pulses
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            width      <= '0;
            lock_cnt   <= '0;
            bus.coin   <= 1'b0;
            bus.reject <= 1'b0;
        end else begin
            state      <= state_nxt;
            width      <= width_nxt;
            lock_cnt   <= lock_nxt;
            bus.coin   <= coin_nxt;
            bus.reject <= reject_nxt;
        end

`ifdef COIN_ACCEPTOR_TOTAL_EN
    // running count of accepted coins, held at 255 once full
    always_ff @(posedge clk or negedge reset)
        if (!reset) bus.coin_total <= '0;
        else if (coin_nxt && bus.coin_total != 8'hFF) bus.coin_total <= bus.coin_total + 8'd1;
`endif
endmodule
